// File: rtl/wo_rom_sched.sv
// Burst scheduler sharing one ROM read port among NREQ requesters; returns id-tagged words.
// Define WO_SCHED_RR_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
module wo_rom_sched #(
    parameter int NREQ = 4,
    parameter int AW   = 8,
    parameter int DW   = 8,
    parameter int IDW  = 2
) (
    input  logic              CS,
    input  logic              cen,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] base,
    input  logic [NREQ*AW-1:0] len,
    output logic [AW-1:0]     rom_add,
    input  logic [DW-1:0]     rom_wop,
    output logic [NREQ-1:0]   gnt,
    output logic              rd_valid,
    output logic [DW-1:0]     rd_data,
    output logic [IDW-1:0]    rd_id,
    output logic              rd_last,
    output logic              done,
    output logic              busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]     state_reg;
    logic [AW-1:0]  base_reg;
    logic [AW-1:0]  len_reg;
    logic [AW:0]    cnt_reg;

    logic [AW-1:0]  base_arr [NREQ];
    logic [AW-1:0]  len_arr  [NREQ];
    logic [IDW-1:0] start_idx;
    logic [IDW-1:0] win_idx;
    logic           win_found;
    logic [NREQ-1:0] win_onehot;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign base_arr[gi] = base[gi*AW +: AW];
        assign len_arr[gi]  = len[gi*AW +: AW];
    end

`ifdef WO_SCHED_RR_EN
    // ptr_reg holds the index where the next search begins (one past the last winner).
    logic [IDW-1:0] ptr_reg;
    assign start_idx = ptr_reg;
`else
    assign start_idx = '0;
`endif

    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(start_idx) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
    end

    assign win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;

    // ROM output is already registered, so data is forwarded and only gated by valid.
    assign rd_data = rd_valid ? rom_wop : '0;

    always_ff @(posedge CS or negedge cen) begin
        if (!cen) begin
            state_reg <= ST_IDLE;
            base_reg  <= '0;
            len_reg   <= '0;
            cnt_reg   <= '0;
            rom_add   <= '0;
            gnt       <= '0;
            rd_valid  <= 1'b0;
            rd_id     <= '0;
            rd_last   <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
`ifdef WO_SCHED_RR_EN
            ptr_reg   <= '0;
`endif
        end else begin
            gnt     <= '0;
            done    <= 1'b0;
            rd_last <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    rd_valid <= 1'b0;
                    busy     <= 1'b0;
                    if (win_found) begin
                        gnt      <= win_onehot;
                        rd_id    <= win_idx;
                        base_reg <= base_arr[win_idx];
                        len_reg  <= len_arr[win_idx];
                        busy     <= 1'b1;
`ifdef WO_SCHED_RR_EN
                        if (win_idx == IDW'(NREQ-1)) ptr_reg <= '0;
                        else                         ptr_reg <= win_idx + IDW'(1);
`endif
                        if (len_arr[win_idx] != '0) begin
                            rom_add   <= base_arr[win_idx];
                            cnt_reg   <= (AW+1)'(1);
                            state_reg <= ST_ISSUE;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    rd_valid <= 1'b1;
                    busy     <= 1'b1;
                    if (cnt_reg < {1'b0, len_reg}) begin
                        rom_add <= base_reg + cnt_reg[AW-1:0];
                        cnt_reg <= cnt_reg + (AW+1)'(1);
                    end else begin
                        rd_last   <= 1'b1;
                        done      <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wo_rom_sched.sv
// Directed bench for wo_rom_sched; a registered ROM model returns addr ^ 8'hA5.
module tb_wo_rom_sched;

    logic        CS = 1'b0;
    logic        cen = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] base = '0;
    logic [31:0] len = '0;
    logic [7:0]  rom_add;
    logic [7:0]  rom_wop = '0;
    logic [3:0]  gnt;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic [1:0]  rd_id;
    logic        rd_last;
    logic        done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    wo_rom_sched #(.NREQ(4), .AW(8), .DW(8), .IDW(2)) dut (
        .CS(CS), .cen(cen), .req(req), .base(base), .len(len),
        .rom_add(rom_add), .rom_wop(rom_wop), .gnt(gnt), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_id(rd_id), .rd_last(rd_last), .done(done), .busy(busy)
    );

    always #5 CS = ~CS;
    always @(posedge CS) rom_wop <= rom_add ^ 8'hA5;

    task automatic set_op(input int id, input logic [7:0] b, input logic [7:0] l);
        base[id*8 +: 8] = b;
        len[id*8 +: 8]  = l;
    endtask

    task automatic test_reset;
        cen = 1'b0;
        req = '0;
        repeat (2) @(negedge CS);
        checks++;
        if ({rom_add, gnt, rd_valid, rd_data, rd_id, rd_last, done, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got add=%h gnt=%b v=%b d=%h id=%0d last=%b done=%b busy=%b exp all 0",
                     rom_add, gnt, rd_valid, rd_data, rd_id, rd_last, done, busy);
        end
        cen = 1'b1;
        @(negedge CS);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
        $display("test_reset done");
    endtask

    // Runs one burst, optionally rewriting the operands right after the grant.
    task automatic run_burst(input string tag, input int id, input logic [7:0] b,
                             input logic [7:0] l, input bit perturb);
        logic [3:0] eg;
        logic [7:0] ea;
        logic [7:0] ed;
        bit         lst;
        eg = 4'b0001 << id;
        set_op(id, b, l);
        req[id] = 1'b1;
        @(negedge CS);
        checks++;
        if (gnt !== eg) begin errors++; $display("FAIL %s_gnt got %b exp %b", tag, gnt, eg); end
        checks++;
        if (rom_add !== b) begin errors++; $display("FAIL %s_first_add got %h exp %h", tag, rom_add, b); end
        checks++;
        if (busy !== 1'b1 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL %s_grant_cycle got busy=%b v=%b exp busy=1 v=0", tag, busy, rd_valid);
        end
        req[id] = 1'b0;
        if (perturb) set_op(id, 8'h77, 8'd9);
        for (int k = 0; k < int'(l); k++) begin
            @(negedge CS);
            ea  = b + 8'((k + 1 < int'(l)) ? k + 1 : int'(l) - 1);
            ed  = (b + 8'(k)) ^ 8'hA5;
            lst = (k == int'(l) - 1);
            checks++;
            if (rd_valid !== 1'b1 || rd_id !== 2'(id) || rd_data !== ed) begin
                errors++;
                $display("FAIL %s_word%0d got v=%b id=%0d d=%h exp v=1 id=%0d d=%h", tag, k, rd_valid, rd_id, rd_data, id, ed);
            end
            checks++;
            if (rom_add !== ea) begin errors++; $display("FAIL %s_add%0d got %h exp %h", tag, k, rom_add, ea); end
            checks++;
            if (rd_last !== lst || done !== lst || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_flags%0d got last=%b done=%b busy=%b exp last=%b done=%b busy=1", tag, k, rd_last, done, busy, lst, lst);
            end
        end
        @(negedge CS);
        checks++;
        if (rd_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0) begin
            errors++;
            $display("FAIL %s_end got v=%b done=%b busy=%b gnt=%b exp 0", tag, rd_valid, done, busy, gnt);
        end
        $display("%s: id=%0d base=%h len=%0d", tag, id, b, l);
    endtask

    task automatic test_single;
        run_burst("single", 1, 8'h10, 8'd4, 1'b0);
    endtask

    task automatic test_wrap;
        run_burst("wrap", 3, 8'hFE, 8'd3, 1'b0);
    endtask

    task automatic test_stability;
        run_burst("stability", 0, 8'h60, 8'd3, 1'b1);
    endtask

    task automatic test_empty;
        logic [7:0] prev;
        prev = rom_add;
        set_op(2, 8'h55, 8'd0);
        req[2] = 1'b1;
        @(negedge CS);
        checks++;
        if (gnt !== 4'b0100 || done !== 1'b1 || rd_id !== 2'd2) begin
            errors++; $display("FAIL empty_grant got gnt=%b done=%b id=%0d exp 0100 1 2", gnt, done, rd_id);
        end
        checks++;
        if (rd_valid !== 1'b0 || rom_add !== prev || busy !== 1'b1) begin
            errors++; $display("FAIL empty_noaccess got v=%b add=%h busy=%b exp v=0 add=%h busy=1", rd_valid, rom_add, busy, prev);
        end
        req[2] = 1'b0;
        @(negedge CS);
        checks++;
        if (done !== 1'b0 || gnt !== 4'b0 || busy !== 1'b0 || rd_valid !== 1'b0 || rom_add !== prev) begin
            errors++; $display("FAIL empty_after got done=%b gnt=%b busy=%b v=%b add=%h exp 0 0 0 0 %h", done, gnt, busy, rd_valid, rom_add, prev);
        end
        $display("empty: id=2 len=0");
    endtask

    task automatic test_back_to_back;
        set_op(1, 8'h20, 8'd1);
        set_op(3, 8'h30, 8'd1);
        req = 4'b1010;
        @(negedge CS);
        checks++;
        if (gnt !== 4'b0010 || rd_id !== 2'd1) begin errors++; $display("FAIL b2b_gnt1 got gnt=%b id=%0d exp 0010 1", gnt, rd_id); end
        req[1] = 1'b0;
        @(negedge CS);
        checks++;
        if (rd_valid !== 1'b1 || done !== 1'b1 || rd_last !== 1'b1 || rd_id !== 2'd1 || rd_data !== (8'h20 ^ 8'hA5)) begin
            errors++; $display("FAIL b2b_word1 got v=%b done=%b last=%b id=%0d d=%h exp 1 1 1 1 %h", rd_valid, done, rd_last, rd_id, rd_data, 8'h20 ^ 8'hA5);
        end
        @(negedge CS);
        checks++;
        if (gnt !== 4'b1000 || rd_id !== 2'd3 || rd_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_gnt3 got gnt=%b id=%0d v=%b busy=%b exp 1000 3 0 1", gnt, rd_id, rd_valid, busy);
        end
        req[3] = 1'b0;
        @(negedge CS);
        checks++;
        if (rd_valid !== 1'b1 || done !== 1'b1 || rd_id !== 2'd3 || rd_data !== (8'h30 ^ 8'hA5)) begin
            errors++; $display("FAIL b2b_word3 got v=%b done=%b id=%0d d=%h exp 1 1 3 %h", rd_valid, done, rd_id, rd_data, 8'h30 ^ 8'hA5);
        end
        @(negedge CS);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%b exp 0", busy); end
        $display("back_to_back: ids 1 then 3");
    endtask

    task automatic test_reset_mid_burst;
        bit bad;
        set_op(3, 8'h40, 8'd5);
        req[3] = 1'b1;
        @(negedge CS);
        req[3] = 1'b0;
        repeat (2) @(negedge CS);
        cen = 1'b0;
        #1;
        checks++;
        if ({rom_add, gnt, rd_valid, rd_data, rd_id, rd_last, done, busy} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got add=%h gnt=%b v=%b d=%h id=%0d last=%b done=%b busy=%b exp all 0",
                     rom_add, gnt, rd_valid, rd_data, rd_id, rd_last, done, busy);
        end
        repeat (2) @(negedge CS);
        cen = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            @(negedge CS);
            if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL midreset_after got activity after release exp none (busy=%b done=%b v=%b)", busy, done, rd_valid); end
        $display("reset_mid_burst: id=3 len=5 abandoned");
    endtask

    task automatic test_contention;
        int got [$];
        int exp_order [5];
`ifdef WO_SCHED_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) set_op(i, 8'(i * 16), 8'd2);
        req = 4'hF;
        for (int c = 0; c < 15; c++) begin
            @(negedge CS);
            for (int i = 0; i < 4; i++) if (gnt[i] === 1'b1) got.push_back(i);
        end
        checks++;
        if (got.size() != 5) begin
            errors++; $display("FAIL contention_count got %0d exp 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] != exp_order[i]) begin errors++; $display("FAIL contention_grant%0d got %0d exp %0d", i, got[i], exp_order[i]); end
            end
        end
        req[0] = 1'b0;
        @(negedge CS);
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL contention_drop0 got %b exp 0010", gnt); end
        req = '0;
        $display("contention: %0d grants observed", got.size());
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while ((busy !== 1'b0 || rd_valid !== 1'b0) && n < 20) begin
            @(negedge CS);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle got busy=%b after %0d cycles exp 0", busy, n); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_wrap;
        test_empty;
        test_stability;
        test_back_to_back;
        test_reset_mid_burst;
        test_contention;
        wait_idle;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
